// File: rtl/ovl_delta_mc_pkg.sv
// ----------------------------------------------------------------------------
// ovl_delta_mc_pkg
// Shared types and the delta computation for the multi-channel OVL delta
// checker.
//   delta_mode_e : DELTA_ABS (plain absolute difference) or DELTA_WRAP
//                  (shortest modular distance)
//   chan_state_e : per-channel FSM states, UNREF / ARMED
//   delta_calc() : change magnitude between two samples of up to MAX_W bits
// ----------------------------------------------------------------------------
package ovl_delta_mc_pkg;

  localparam int MAX_W = 32;

  typedef enum logic [0:0] {
    DELTA_ABS  = 1'b0,
    DELTA_WRAP = 1'b1
  } delta_mode_e;

  typedef enum logic [0:0] {
    UNREF = 1'b0,
    ARMED = 1'b1
  } chan_state_e;

  // Inputs are zero-extended samples of 'width' bits (2..MAX_W). The extra
  // top bit of the intermediates lets 2^width be represented for width=32.
  function automatic logic [MAX_W-1:0] delta_calc(
    input logic [MAX_W-1:0] cur,
    input logic [MAX_W-1:0] prev,
    input int               width,
    input delta_mode_e      mode
  );
    logic [MAX_W:0] modulus;
    logic [MAX_W:0] d;
    logic [MAX_W:0] alt;
    logic [MAX_W:0] diff;
    logic [MAX_W-1:0] result;
    modulus = 33'd1 << width;
    d       = ({1'b0, cur} - {1'b0, prev}) & (modulus - 33'd1);
    alt     = modulus - d;
    if (cur >= prev) begin
      diff = {1'b0, cur - prev};
    end else begin
      diff = {1'b0, prev - cur};
    end
    case (mode)
      DELTA_ABS:  result = diff[MAX_W-1:0];
      DELTA_WRAP: result = (d <= alt) ? d[MAX_W-1:0] : alt[MAX_W-1:0];
      default:    result = diff[MAX_W-1:0];
    endcase
    return result;
  endfunction

endpackage

// File: rtl/ovl_delta_mc_chan.sv
// ----------------------------------------------------------------------------
// ovl_delta_mc_chan
// One channel of the delta checker: UNREF/ARMED FSM, reference register,
// delta compare, sticky flag and saturating fire counter.
// Optional feature macro: OVL_DELTA_MC_XCHECK_EN (X/Z detection on samples).
// Ports:
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_enable             check enable for this channel
//   i_clear              synchronous clear of sticky flag and counter
//   i_test_expr          sampled expression (WIDTH bits)
//   o_fire               one-cycle violation pulse
//   o_fire_sticky        violation seen since last clear/reset
//   o_fire_x             one-cycle X/Z pulse (0 when feature not built)
//   o_fire_count         saturating violation count (CNT_W bits)
// ----------------------------------------------------------------------------
module ovl_delta_mc_chan
  import ovl_delta_mc_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int MIN        = 1,
  parameter int MAX        = 1,
  parameter int DELTA_MODE = 0,
  parameter int CNT_W      = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_test_expr,
  output logic             o_fire,
  output logic             o_fire_sticky,
  output logic             o_fire_x,
  output logic [CNT_W-1:0] o_fire_count
);

  localparam delta_mode_e      MODE    = (DELTA_MODE == 1) ? DELTA_WRAP : DELTA_ABS;
  localparam logic [31:0]      MIN_U   = 32'(MIN);
  localparam logic [31:0]      MAX_U   = 32'(MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  chan_state_e      r_state;
  logic [WIDTH-1:0] r_prev;
  logic             r_fire;
  logic             r_sticky;
  logic [CNT_W-1:0] r_count;

  chan_state_e      w_state_nxt;
  logic [WIDTH-1:0] w_prev_nxt;
  logic             w_xbad;
  logic             w_xpulse;
  logic             w_changed;
  logic [31:0]      w_delta;
  logic             w_out_of_range;
  logic             w_viol;

`ifdef OVL_DELTA_MC_XCHECK_EN
  assign w_xbad = $isunknown(i_test_expr);
`else
  assign w_xbad = 1'b0;
`endif

  assign w_changed      = (i_test_expr != r_prev);
  assign w_delta        = delta_calc(32'(i_test_expr), 32'(r_prev), WIDTH, MODE);
  assign w_out_of_range = (w_delta < MIN_U) || (w_delta > MAX_U);
  assign w_viol         = (r_state == ARMED) && i_enable && !w_xbad &&
                          w_changed && w_out_of_range;

  // Next-state, reference update and X pulse decision.
  always_comb begin
    w_state_nxt = r_state;
    w_prev_nxt  = r_prev;
    w_xpulse    = 1'b0;
    case (r_state)
      UNREF: begin
        // An X/Z sample never becomes the reference.
        if (i_enable && !w_xbad) begin
          w_state_nxt = ARMED;
          w_prev_nxt  = i_test_expr;
        end else begin
          w_state_nxt = UNREF;
        end
      end
      ARMED: begin
        if (!i_enable) begin
          // Drop the reference so a re-enable never checks a stale value.
          w_state_nxt = UNREF;
        end else if (w_xbad) begin
          w_xpulse = 1'b1;
        end else if (w_changed) begin
          // Reference follows the data whether or not the step was legal.
          w_prev_nxt = i_test_expr;
        end else begin
          w_prev_nxt = r_prev;
        end
      end
      default: begin
        w_state_nxt = UNREF;
      end
    endcase
  end

  // Channel state, reference, fire pulse, sticky flag and counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= UNREF;
      r_prev   <= '0;
      r_fire   <= 1'b0;
      r_sticky <= 1'b0;
      r_count  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_prev  <= w_prev_nxt;
      r_fire  <= w_viol;
      // Clear beats a same-cycle violation; the fire pulse still goes out.
      if (i_clear) begin
        r_sticky <= 1'b0;
        r_count  <= '0;
      end else if (w_viol) begin
        r_sticky <= 1'b1;
        if (r_count != CNT_MAX) begin
          r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

`ifdef OVL_DELTA_MC_XCHECK_EN
  logic r_fire_x;

  // Registered X/Z pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fire_x <= 1'b0;
    end else begin
      r_fire_x <= w_xpulse;
    end
  end

  assign o_fire_x = r_fire_x;
`else
  logic w_xpulse_unused;
  assign w_xpulse_unused = w_xpulse;
  assign o_fire_x        = 1'b0;
`endif

  assign o_fire        = r_fire;
  assign o_fire_sticky = r_sticky;
  assign o_fire_count  = r_count;

endmodule

// File: rtl/ovl_delta_mc.sv
// ----------------------------------------------------------------------------
// ovl_delta_mc
// Multi-channel delta checker. Each of NUM_CH WIDTH-bit test expressions is
// checked independently: a change whose magnitude lies outside [MIN, MAX]
// fires that channel. All outputs are registered.
// Optional feature macro: OVL_DELTA_MC_XCHECK_EN (X/Z detection, o_fire_x).
// Ports:
//   i_clk, i_reset   sampling clock, synchronous active-high reset
//   i_enable         per-channel check enable (NUM_CH)
//   i_clear          clear all sticky flags and counters
//   i_test_expr      channel c at [c*WIDTH +: WIDTH]
//   o_fire           per-channel one-cycle violation pulse
//   o_fire_sticky    per-channel sticky violation flag
//   o_fire_x         per-channel one-cycle X/Z pulse
//   o_fire_count     channel c count at [c*CNT_W +: CNT_W], saturating
// ----------------------------------------------------------------------------
module ovl_delta_mc
  import ovl_delta_mc_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int WIDTH      = 4,
  parameter int MIN        = 1,
  parameter int MAX        = 1,
  parameter int DELTA_MODE = 0,
  parameter int CNT_W      = 8
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [NUM_CH-1:0]       i_enable,
  input  logic                    i_clear,
  input  logic [NUM_CH*WIDTH-1:0] i_test_expr,
  output logic [NUM_CH-1:0]       o_fire,
  output logic [NUM_CH-1:0]       o_fire_sticky,
  output logic [NUM_CH-1:0]       o_fire_x,
  output logic [NUM_CH*CNT_W-1:0] o_fire_count
);

  localparam longint MAX_LEGAL = (64'sd1 <<< WIDTH) - 64'sd1;

  // Elaboration-time parameter sanity.
  if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
    $fatal(1, "ovl_delta_mc: NUM_CH must be 1..32");
  end
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "ovl_delta_mc: WIDTH must be 2..32");
  end
  if (MIN < 0 || MIN > MAX) begin : g_bad_min
    $fatal(1, "ovl_delta_mc: need 0 <= MIN <= MAX");
  end
  if (longint'(MAX) > MAX_LEGAL) begin : g_bad_max
    $fatal(1, "ovl_delta_mc: MAX exceeds 2^WIDTH-1");
  end
  if (DELTA_MODE != 0 && DELTA_MODE != 1) begin : g_bad_mode
    $fatal(1, "ovl_delta_mc: DELTA_MODE must be 0 or 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $fatal(1, "ovl_delta_mc: CNT_W must be >= 1");
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ovl_delta_mc_chan #(
      .WIDTH      (WIDTH),
      .MIN        (MIN),
      .MAX        (MAX),
      .DELTA_MODE (DELTA_MODE),
      .CNT_W      (CNT_W)
    ) u_chan (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_enable      (i_enable[c]),
      .i_clear       (i_clear),
      .i_test_expr   (i_test_expr[c*WIDTH +: WIDTH]),
      .o_fire        (o_fire[c]),
      .o_fire_sticky (o_fire_sticky[c]),
      .o_fire_x      (o_fire_x[c]),
      .o_fire_count  (o_fire_count[c*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_ovl_delta_mc.sv
// ----------------------------------------------------------------------------
// tb_ovl_delta_mc
// Directed bench. Each step drives one sample and queues the hand-computed
// outputs expected after the sampling edge; a monitor pops and compares.
// dut   : NUM_CH=2, WIDTH=4, MIN=2, MAX=5, DELTA_MODE=0, CNT_W=2
// dut_w : same but DELTA_MODE=1; only its ch0 fire is checked, where flagged.
// ----------------------------------------------------------------------------
module tb_ovl_delta_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] en;
  logic       clr;
  logic [3:0] v0;
  logic [3:0] v1;

  logic [1:0] fire, sticky, fx;
  logic [3:0] cnt;
  logic [1:0] fire_w, sticky_w, fx_w;
  logic [3:0] cnt_w;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [1:0] fire;
    logic [1:0] sticky;
    logic [3:0] cnt;
    logic [1:0] fx;
    logic       chk_w;
    logic       fw;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  ovl_delta_mc #(
    .NUM_CH(2), .WIDTH(4), .MIN(2), .MAX(5), .DELTA_MODE(0), .CNT_W(2)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_clear(clr),
    .i_test_expr({v1, v0}),
    .o_fire(fire), .o_fire_sticky(sticky), .o_fire_x(fx), .o_fire_count(cnt)
  );

  ovl_delta_mc #(
    .NUM_CH(2), .WIDTH(4), .MIN(2), .MAX(5), .DELTA_MODE(1), .CNT_W(2)
  ) dut_w (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_clear(clr),
    .i_test_expr({v1, v0}),
    .o_fire(fire_w), .o_fire_sticky(sticky_w), .o_fire_x(fx_w), .o_fire_count(cnt_w)
  );

  task automatic cmp(input string nm, input string what,
                     input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got %b, expected %b", nm, what, act, req);
    end
  endtask

  // Monitor: outputs of the step driven before this edge, sampled #1 later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        cmp(e.name, "fire",   {2'b00, fire},   {2'b00, e.fire});
        cmp(e.name, "sticky", {2'b00, sticky}, {2'b00, e.sticky});
        cmp(e.name, "count",  cnt,             e.cnt);
        cmp(e.name, "fire_x", {2'b00, fx},     {2'b00, e.fx});
        if (e.chk_w) begin
          cmp(e.name, "wrap_fire0", {3'b000, fire_w[0]}, {3'b000, e.fw});
        end
      end
    end
  end

  task automatic step(input string nm, input logic r, input logic [1:0] e_n,
                      input logic c, input logic [3:0] a, input logic [3:0] b,
                      input logic [1:0] ef, input logic [1:0] es,
                      input logic [3:0] ec, input logic [1:0] efx,
                      input logic cw, input logic efw);
    exp_t e;
    @(negedge clk);
    rst = r; en = e_n; clr = c; v0 = a; v1 = b;
    e.name = nm; e.fire = ef; e.sticky = es; e.cnt = ec; e.fx = efx;
    e.chk_w = cw; e.fw = efw;
    q.push_back(e);
  endtask

  initial begin
    logic [3:0] sat_v [5];
    logic [1:0] sat_c [5];
    logic [3:0] xval;
    sat_v = '{4'd2, 4'd1, 4'd2, 4'd1, 4'd2};
    sat_c = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    rst = 1'b1; en = 2'b00; clr = 1'b0; v0 = 4'd0; v1 = 4'd0;

    // Reset held, then legal sequence 2,4,6.
    step("rst_a",  1'b1, 2'b01, 1'b0, 4'd1, 4'd0, 2'b00, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0);
    step("rst_b",  1'b1, 2'b01, 1'b0, 4'd2, 4'd0, 2'b00, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0);
    step("rst_c",  1'b1, 2'b01, 1'b0, 4'd0, 4'd0, 2'b00, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0);
    step("ref2",   1'b0, 2'b01, 1'b0, 4'd2, 4'd0, 2'b00, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0);
    step("d2_4",   1'b0, 2'b01, 1'b0, 4'd4, 4'd0, 2'b00, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0);
    step("d2_6",   1'b0, 2'b01, 1'b0, 4'd6, 4'd0, 2'b00, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0);
    // 2 then 3 (delta 1) fires, then 3 -> 9 (delta 6) fires again.
    step("d4_2",   1'b0, 2'b01, 1'b0, 4'd2, 4'd0, 2'b00, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0);
    step("d1_3",   1'b0, 2'b01, 1'b0, 4'd3, 4'd0, 2'b01, 2'b01, 4'h1, 2'b00, 1'b0, 1'b0);
    step("hold3",  1'b0, 2'b01, 1'b0, 4'd3, 4'd0, 2'b00, 2'b01, 4'h1, 2'b00, 1'b0, 1'b0);
    step("d6_9",   1'b0, 2'b01, 1'b0, 4'd9, 4'd0, 2'b01, 2'b01, 4'h2, 2'b00, 1'b0, 1'b0);
    // Hold 7 for five cycles.
    step("d2_7",   1'b0, 2'b01, 1'b0, 4'd7, 4'd0, 2'b00, 2'b01, 4'h2, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step("hold7", 1'b0, 2'b01, 1'b0, 4'd7, 4'd0, 2'b00, 2'b01, 4'h2, 2'b00, 1'b0, 1'b0);
    end
    // Disable with 15, re-enable with 1: reference only.
    step("dis15",  1'b0, 2'b00, 1'b0, 4'd15, 4'd0, 2'b00, 2'b01, 4'h2, 2'b00, 1'b0, 1'b0);
    step("reen1",  1'b0, 2'b01, 1'b0, 4'd1,  4'd0, 2'b00, 2'b01, 4'h2, 2'b00, 1'b0, 1'b0);
    // 14 -> 1: abs delta 13 fires, wrap delta 3 does not.
    step("dis14",  1'b0, 2'b00, 1'b0, 4'd14, 4'd0, 2'b00, 2'b01, 4'h2, 2'b00, 1'b0, 1'b0);
    step("ref14",  1'b0, 2'b01, 1'b0, 4'd14, 4'd0, 2'b00, 2'b01, 4'h2, 2'b00, 1'b1, 1'b0);
    step("d13_1",  1'b0, 2'b01, 1'b0, 4'd1,  4'd0, 2'b01, 2'b01, 4'h3, 2'b00, 1'b1, 1'b0);
    // Clear, then five back-to-back violations saturating at 3.
    step("clr",    1'b0, 2'b01, 1'b1, 4'd1,  4'd0, 2'b00, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step("sat", 1'b0, 2'b01, 1'b0, sat_v[i], 4'd0, 2'b01, 2'b01, {2'b00, sat_c[i]},
           2'b00, (i == 0), 1'b1);
    end
    // Clear together with a violation: clear wins, fire still pulses.
    step("clr_vio", 1'b0, 2'b01, 1'b1, 4'd1, 4'd0, 2'b01, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0);
    step("aft_clr", 1'b0, 2'b01, 1'b0, 4'd1, 4'd0, 2'b00, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0);
    // Mid-operation reset; first sample afterwards is reference only.
    step("pre_rst", 1'b0, 2'b01, 1'b0, 4'd2,  4'd0, 2'b01, 2'b01, 4'h1, 2'b00, 1'b0, 1'b0);
    step("rst_mid", 1'b1, 2'b01, 1'b0, 4'd9,  4'd0, 2'b00, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0);
    step("ref15",   1'b0, 2'b01, 1'b0, 4'd15, 4'd0, 2'b00, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0);
    step("d3_12",   1'b0, 2'b01, 1'b0, 4'd12, 4'd0, 2'b00, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0);
    // Channel 1 independent of channel 0.
    step("ch1_ref", 1'b0, 2'b11, 1'b0, 4'd12, 4'd5, 2'b00, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0);
    step("ch1_d1",  1'b0, 2'b11, 1'b0, 4'd12, 4'd6, 2'b10, 2'b10, 4'h4, 2'b00, 1'b0, 1'b0);
    step("ch1_d2",  1'b0, 2'b11, 1'b0, 4'd12, 4'd8, 2'b00, 2'b10, 4'h4, 2'b00, 1'b0, 1'b0);
`ifdef OVL_DELTA_MC_XCHECK_EN
    xval = 4'bx1x0;
    step("x_arm5",  1'b0, 2'b11, 1'b0, 4'd12, 4'd5, 2'b00, 2'b10, 4'h4, 2'b00, 1'b0, 1'b0);
    step("x_pulse", 1'b0, 2'b11, 1'b0, 4'd12, xval, 2'b00, 2'b10, 4'h4, 2'b10, 1'b0, 1'b0);
    step("x_aft7",  1'b0, 2'b11, 1'b0, 4'd12, 4'd7, 2'b00, 2'b10, 4'h4, 2'b00, 1'b0, 1'b0);
`else
    xval = 4'd0;
`endif
    // Drain: the monitor needs one more edge per queued step.
    repeat (4) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
